fetch_sequencer: RTL
====================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, meaning address/PC width.
REQ-002 SHALL have parameter REG_WIDTH, default 8, meaning opcode/data byte width.
REQ-003 SHALL have parameter RESET_PC, default 16'h0000, meaning PC value loaded on reset.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on posedge clk.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port halt  input  1  stop fetching at next instruction boundary.
REQ-007 SHALL have port mem_addr  output  ADDR_WIDTH  fetch address.
REQ-008 SHALL have port mem_rd  output  1  one-cycle read request strobe.
REQ-009 SHALL have port mem_data  input  REG_WIDTH  read data.
REQ-010 SHALL have port mem_valid  input  1  mem_data valid this cycle; latency of 1 or more cycles after mem_rd.
REQ-011 SHALL have port instruction  output  REG_WIDTH  latched opcode.
REQ-012 SHALL have port operand  output  ADDR_WIDTH  latched operand: low byte in [7:0], high byte in [15:8], unused bytes 0.
REQ-013 SHALL have port instruction_ready  output  1  opcode/operand valid to the decoder.
REQ-014 SHALL have port instruction_done  input  1  decoder finished the current instruction.
REQ-015 SHALL have port pc_load  input  1  redirect PC (jump/branch).
REQ-016 SHALL have port pc_load_val  input  ADDR_WIDTH  redirect target.
REQ-017 SHALL have port pc  output  ADDR_WIDTH  current program counter.
REQ-018 SHALL have port illegal  output  1  one-cycle pulse when the opcode has cc=2'b11.
REQ-019 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-020 SHALL implement states IDLE, REQ_OP, WAIT_OP, REQ_LO, WAIT_LO, REQ_HI, WAIT_HI, ISSUE, WAIT_DONE.
REQ-021 IDLE: SHALL move to REQ_OP when halt=0 and stay in IDLE otherwise.
REQ-022 In each REQ_* state, SHALL drive mem_rd=1 for exactly one cycle with mem_addr=pc, then move to the matching WAIT_*.
REQ-023 In each WAIT_* state, on mem_valid=1 SHALL latch mem_data, set pc<=pc+1 (wrapping FFFF->0000), and advance.
REQ-024 mem_valid SHALL be ignored in all non-WAIT states.
REQ-025 On opcode capture, SHALL clear operand and compute the operand count N from aaa=op[7:5], bbb=op[4:2], cc=op[1:0].
REQ-026 cc=01: N=2 for bbb in {011,110,111}, otherwise N=1.
REQ-027 cc=10: N=1 for bbb in {000,001,101}, N=2 for bbb in {011,111}, otherwise N=0.
REQ-028 cc=00, bbb=000: N=2 if aaa=001, N=0 if aaa in {000,010,011}, otherwise N=1.
REQ-029 cc=00, other bbb: N=1 for {001,100,101}, N=2 for {011,111}, N=0 for {010,110}.
REQ-030 cc=11: N=0, and SHALL pulse illegal for one cycle in the cycle after opcode capture.
REQ-031 After WAIT_OP: N=0 -> ISSUE; N>=1 -> REQ_LO. After WAIT_LO: N=2 -> REQ_HI, otherwise ISSUE. After WAIT_HI -> ISSUE.
REQ-032 ISSUE: SHALL set instruction_ready=1 and go to WAIT_DONE; instruction and operand SHALL hold stable until the next opcode capture.
REQ-033 WAIT_DONE: SHALL hold instruction_ready=1 until instruction_done=1 is sampled; then instruction_ready=0 the next cycle, and go to IDLE if halt=1, else REQ_OP.
REQ-034 instruction_ready SHALL be low for at least 2 cycles between instructions, so the decoder always sees a rising edge.
REQ-035 pc_load SHALL take effect only when sampled together with instruction_done in WAIT_DONE: pc<=pc_load_val, and the next fetch uses the new PC. pc_load in any other state SHALL be ignored.
REQ-036 halt SHALL be sampled only in IDLE and at instruction completion; a fetch already in flight SHALL complete and issue.
REQ-037 instruction_done outside WAIT_DONE SHALL be ignored.
REQ-038 Minimum latency for an N=0 opcode with 1-cycle memory: mem_rd to instruction_ready = 3 cycles.

Reset
REQ-039 On reset_n=0, SHALL immediately set state=IDLE, pc=RESET_PC, mem_rd=0, mem_addr=0, instruction=0, operand=0, instruction_ready=0, illegal=0, busy=0.
REQ-040 Reset asserted mid-fetch or mid-WAIT_DONE SHALL abandon the instruction; a mem_valid arriving after release SHALL be ignored.
REQ-041 After reset_n rises, the first mem_rd SHALL occur no earlier than the second clk edge, with mem_addr=RESET_PC.

Verification
REQ-042 Memory {0000:A9, 0001:42}, 1-cycle latency, done pulsed 2 cycles after ready -> instruction=A9, operand=0042, N=1, pc=0002, then fetch at 0002.
REQ-043 Opcode 8D at 0010 with operand bytes 34 12, memory latency 3 -> operand=1234, pc=0013, exactly 3 mem_rd pulses.
REQ-044 Opcode EA (N=0) at FFFF -> no operand read, operand=0000, pc wraps to 0000.
REQ-045 Opcode 4C with pc_load=1, pc_load_val=C000 asserted together with done -> next mem_rd has mem_addr=C000; a pc_load pulse during WAIT_OP has no effect.
REQ-046 Opcode 03 -> illegal pulses for 1 cycle, instruction issued with operand=0000.
REQ-047 halt raised during WAIT_LO -> instruction still issues, and after done the block enters IDLE with busy=0; reset during WAIT_HI -> pc=RESET_PC and instruction_ready stays 0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: reads an opcode plus 0-2 operand bytes from a
// byte-wide memory, presents them to the decoder and waits for completion.
module fetch_sequencer #(
   parameter int                    ADDR_WIDTH = 16,
   parameter int                    REG_WIDTH  = 8,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 16'h0000
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  halt,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_rd,
   input  logic [REG_WIDTH-1:0]  mem_data,
   input  logic                  mem_valid,
   output logic [REG_WIDTH-1:0]  instruction,
   output logic [ADDR_WIDTH-1:0] operand,
   output logic                  instruction_ready,
   input  logic                  instruction_done,
   input  logic                  pc_load,
   input  logic [ADDR_WIDTH-1:0] pc_load_val,
   output logic [ADDR_WIDTH-1:0] pc,
   output logic                  illegal,
   output logic                  busy
);

   typedef enum logic [3:0] {
      IDLE,
      REQ_OP,
      WAIT_OP,
      REQ_LO,
      WAIT_LO,
      REQ_HI,
      WAIT_HI,
      ISSUE,
      WAIT_DONE
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] PC_INC = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   state_t     state;
   state_t     next_state;
   logic [1:0] n_cnt;
   logic       started;

   // Operand byte count from the aaa/bbb/cc fields of the opcode.
   function automatic logic [1:0] op_count(input logic [7:0] op);
      logic [2:0] aaa;
      logic [2:0] bbb;
      logic [1:0] n;
      aaa = op[7:5];
      bbb = op[4:2];
      n   = 2'd0;
      case (op[1:0])
         2'b01: n = (bbb == 3'b011 || bbb == 3'b110 || bbb == 3'b111) ? 2'd2 : 2'd1;
         2'b10: begin
            case (bbb)
               3'b000, 3'b001, 3'b101: n = 2'd1;
               3'b011, 3'b111:         n = 2'd2;
               default:                n = 2'd0;
            endcase
         end
         2'b00: begin
            if (bbb == 3'b000) begin
               if (aaa == 3'b001)
                  n = 2'd2;
               else if (aaa == 3'b000 || aaa == 3'b010 || aaa == 3'b011)
                  n = 2'd0;
               else
                  n = 2'd1;
            end else begin
               case (bbb)
                  3'b001, 3'b100, 3'b101: n = 2'd1;
                  3'b011, 3'b111:         n = 2'd2;
                  default:                n = 2'd0;
               endcase
            end
         end
         default: n = 2'd0;
      endcase
      return n;
   endfunction

   assign mem_rd   = (state == REQ_OP) || (state == REQ_LO) || (state == REQ_HI);
   assign mem_addr = mem_rd ? pc : '0;
   assign busy     = (state != IDLE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         // Leaving IDLE waits one edge after reset release so the first
         // request is never issued on the release edge itself.
         IDLE:      if (started && !halt) next_state = REQ_OP;
         REQ_OP:    next_state = WAIT_OP;
         WAIT_OP:   if (mem_valid) next_state = (op_count(mem_data[7:0]) == 2'd0) ? ISSUE : REQ_LO;
         REQ_LO:    next_state = WAIT_LO;
         WAIT_LO:   if (mem_valid) next_state = (n_cnt == 2'd2) ? REQ_HI : ISSUE;
         REQ_HI:    next_state = WAIT_HI;
         WAIT_HI:   if (mem_valid) next_state = ISSUE;
         ISSUE:     next_state = WAIT_DONE;
         WAIT_DONE: if (instruction_done) next_state = halt ? IDLE : REQ_OP;
         default:   next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc                <= RESET_PC;
         instruction       <= '0;
         operand           <= '0;
         n_cnt             <= 2'd0;
         illegal           <= 1'b0;
         instruction_ready <= 1'b0;
         started           <= 1'b0;
      end else begin
         started           <= 1'b1;
         illegal           <= 1'b0;
         instruction_ready <= (next_state == WAIT_DONE);
         case (state)
            WAIT_OP: begin
               if (mem_valid) begin
                  instruction <= mem_data;
                  operand     <= '0;
                  n_cnt       <= op_count(mem_data[7:0]);
                  illegal     <= (mem_data[1:0] == 2'b11);
                  pc          <= pc + PC_INC;
               end
            end
            WAIT_LO: begin
               if (mem_valid) begin
                  operand[REG_WIDTH-1:0] <= mem_data;
                  pc                     <= pc + PC_INC;
               end
            end
            WAIT_HI: begin
               if (mem_valid) begin
                  operand[2*REG_WIDTH-1:REG_WIDTH] <= mem_data;
                  pc                               <= pc + PC_INC;
               end
            end
            WAIT_DONE: begin
               if (instruction_done && pc_load)
                  pc <= pc_load_val;
            end
            default: ;
         endcase
      end
   end

endmodule
